// File: rtl/altair_panel_pkg.sv
// Shared definitions for the Altair front-panel input logic: event code
// layout, scanner FSM encoding and the hardware column limit.
package altair_panel_pkg;

    localparam int MAX_COLS     = 8;
    localparam int EV_WIDTH     = 8;
    localparam int EV_PRESS_BIT = 7;
    localparam int EV_COL_LSB   = 3;
    localparam int EV_ROW_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_EMIT   = 3'd4
    } scan_state_e;

    // Pack a key event: press flag, column and row; bit 6 stays zero.
    function automatic logic [EV_WIDTH-1:0] makeEvCode(input logic       press,
                                                       input logic [2:0] col,
                                                       input logic [2:0] row);
        logic [EV_WIDTH-1:0] code;
        code                      = '0;
        code[EV_PRESS_BIT]        = press;
        code[EV_COL_LSB +: 3]     = col;
        code[EV_ROW_LSB +: 3]     = row;
        return code;
    endfunction

endpackage

// File: rtl/panel_switch_scanner_if.sv
// Press/release event stream from the switch scanner to the front-panel
// controller. The scanner is the master; the controller is the slave.
interface panel_switch_scanner_if;
    import altair_panel_pkg::*;

    logic                ev_valid;
    logic                ev_ready;
    logic [EV_WIDTH-1:0] ev_code;

    modport master (output ev_valid, output ev_code, input ev_ready);
    modport slave  (input ev_valid, input ev_code, output ev_ready);

endinterface

// File: rtl/panel_switch_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous sense lines.
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two register stages give a metastable first flop a full cycle to settle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/panel_switch_scanner.sv
// Front-panel switch matrix scanner: strobes one open-drain column at a time,
// samples the eight active-low sense rows, debounces each column and reports
// committed changes both as a switch image and as a press/release event stream.
module panel_switch_scanner
    import altair_panel_pkg::*;
#(
    parameter int NCOL     = 4,
    parameter int SETTLE   = 64,
    parameter int DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 scan_en,
    output logic [7:0]           dir,
    input  logic [7:0]           sense,
    output logic [NCOL*8-1:0]    switches,
    output logic                 scan_busy,
    panel_switch_scanner_if.master ev
);

    localparam int          SW          = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [3:0]  DEB         = 4'(DEBOUNCE);
    localparam logic [2:0]  COL_LAST    = 3'(NCOL - 1);

    scan_state_e     r_state;
    scan_state_e     w_nextState;

    logic [2:0]      r_col;
    logic [2:0]      r_row;
    logic [SW-1:0]   r_settle;
    logic [7:0]      r_rowS;
    logic [7:0]      r_diff;
    logic [7:0]      r_cand   [MAX_COLS];
    logic [3:0]      r_cnt    [MAX_COLS];
    logic [7:0]      r_stable [MAX_COLS];

    logic [7:0]      w_senseSync;
    logic [7:0]      w_samp;
    logic [7:0]      w_colOneHot;
    logic [7:0]      w_newCand;
    logic [3:0]      w_newCnt;
    logic            w_commit;
    logic            w_rowDone;
    logic            w_advance;
    logic            w_evValid;
    logic [EV_WIDTH-1:0] w_evCode;

    sync2 #(.WIDTH(8)) u_senseSync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (sense),
        .o_q    (w_senseSync)
    );

    // Rows are pulled low when a key in the driven column is closed.
    assign w_samp      = ~w_senseSync;
    assign w_colOneHot = 8'b1 << r_col;

    genvar c;
    for (c = 0; c < NCOL; c++) begin : g_switches
        assign switches[c*8 +: 8] = r_stable[c];
    end

    // Debounce decision for the current column, used only in the UPDATE cycle.
    always_comb begin
        w_newCand = r_cand[r_col];
        w_newCnt  = 4'd1;
        if (r_rowS == r_cand[r_col]) begin
            w_newCnt = (r_cnt[r_col] >= DEB) ? DEB : r_cnt[r_col] + 4'd1;
        end else begin
            w_newCand = r_rowS;
        end
        w_commit = (w_newCnt >= DEB) && (w_newCand != r_stable[r_col]);
    end

    // Scanner state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode; EMIT holds until the consumer takes the event.
    always_comb begin
        w_nextState = r_state;
        dir         = 8'h00;
        w_evValid   = 1'b0;
        w_evCode    = '0;
        w_rowDone   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (scan_en) begin
                    w_nextState = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                dir = w_colOneHot;
                if (r_settle == SETTLE_LAST) begin
                    w_nextState = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                dir         = w_colOneHot;
                w_nextState = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (w_commit) begin
                    w_nextState = ST_EMIT;
                end else begin
                    w_advance   = 1'b1;
                    w_nextState = scan_en ? ST_DRIVE : ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (r_diff[r_row]) begin
                    w_evValid = 1'b1;
                    w_evCode  = makeEvCode(r_stable[r_col][r_row], r_col, r_row);
                    w_rowDone = ev.ev_ready;
                end else begin
                    w_rowDone = 1'b1;
                end
                if (w_rowDone && (r_row == 3'd7)) begin
                    w_advance   = 1'b1;
                    w_nextState = scan_en ? ST_DRIVE : ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign ev.ev_valid = w_evValid;
    assign ev.ev_code  = w_evCode;
    assign scan_busy   = (r_state != ST_IDLE);

    // Column datapath: settle timer, sample capture, debounce commit and row walk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col    <= 3'd0;
            r_row    <= 3'd0;
            r_settle <= '0;
            r_rowS   <= 8'h00;
            r_diff   <= 8'h00;
            for (int i = 0; i < MAX_COLS; i++) begin
                r_cand[i]   <= 8'h00;
                r_cnt[i]    <= 4'd0;
                r_stable[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_col    <= 3'd0;
                    r_settle <= '0;
                end
                ST_DRIVE: begin
                    if (r_settle != SETTLE_LAST) begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_rowS <= w_samp;
                end
                ST_UPDATE: begin
                    r_cand[r_col] <= w_newCand;
                    r_cnt[r_col]  <= w_newCnt;
                    if (w_commit) begin
                        r_stable[r_col] <= w_newCand;
                        r_diff          <= w_newCand ^ r_stable[r_col];
                        r_row           <= 3'd0;
                    end
                end
                ST_EMIT: begin
                    if (w_rowDone && (r_row != 3'd7)) begin
                        r_row <= r_row + 3'd1;
                    end
                end
                default: begin
                end
            endcase
            if (w_advance) begin
                r_col    <= (r_col == COL_LAST) ? 3'd0 : r_col + 3'd1;
                r_settle <= '0;
            end
        end
    end

endmodule
